// File: rtl/shift_seq_ctrl.sv
// Shift-register sequencer: accepts a load-and-shift command, performs the
// requested single-bit shifts, and pulses done once the result is final.
`timescale 1ns/1ps
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_d,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_dir,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] remaining;
  logic             dir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      q         <= '0;
      remaining <= '0;
      dir       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            q         <= cmd_d;
            remaining <= cmd_count;
            dir       <= cmd_dir;
            state     <= (cmd_count != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          q         <= dir ? {ser_in, q[WIDTH-1:1]} : {q[WIDTH-2:0], ser_in};
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ser_out previews the bit that the next SHIFT edge pushes out.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state == S_SHIFT) || (state == S_DONE);
    done      = (state == S_DONE);
    ser_out   = 1'b0;
    if (state == S_SHIFT) ser_out = dir ? q[0] : q[WIDTH-1];
  end

endmodule
